// File: rtl/binary_erosion_3x3.sv
// binary_erosion_3x3
//   3x3 morphological erosion of a 1-bit pixel stream. Two 1-bit line buffers
//   supply rows r-1 and r-2, a 3x3 window shift register holds the
//   neighbourhood, and a registered AND reduction produces the output.
//   Every output lags its input by exactly 2 cycles. The eroded image is
//   therefore shifted down and right by one pixel.
//
// Parameters
//   IMG_WIDTH : max active pixels per line (line-buffer depth)
//   CNT_W     : column/row counter width, 2^CNT_W > IMG_WIDTH and > line count
//
// Ports
//   clk, rst_n           : pixel clock, asynchronous active-low reset
//   vsync_in, hsync_in   : frame/line syncs (frame starts on vsync rising edge)
//   de_in, pix_in        : pixel valid and binary pixel (1 = foreground)
//   erode_en             : 1 = erosion, 0 = delay-matched bypass
//   vsync_out, hsync_out : syncs delayed 2 cycles
//   de_out, pix_out      : de delayed 2 cycles, eroded pixel aligned with it
module binary_erosion_3x3 #(
    parameter int unsigned IMG_WIDTH = 640,
    parameter int unsigned CNT_W     = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_in,
    input  logic hsync_in,
    input  logic de_in,
    input  logic pix_in,
    input  logic erode_en,
    output logic vsync_out,
    output logic hsync_out,
    output logic de_out,
    output logic pix_out
);

    localparam int unsigned      AW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] ROW_MAX = '1;

    logic [CNT_W-1:0] col_cnt_q, row_cnt_q;
    logic             vsync_s1_q, hsync_s1_q, de_s1_q, pix_s1_q, valid_s1_q;
    logic [2:0]       win_top_q, win_mid_q, win_bot_q;   // rows r-2, r-1, r

    logic             lb0 [IMG_WIDTH];                   // row r-1
    logic             lb1 [IMG_WIDTH];                   // row r-2

    logic             in_range, vs_rise, de_fall, lb0_rd, lb1_rd, valid_d;
    logic [AW-1:0]    lb_addr;

    always_comb begin
        in_range = (col_cnt_q < WIDTH_C);
        // Only meaningful when in_range; truncation is safe under that guard.
        lb_addr  = col_cnt_q[AW-1:0];
        lb0_rd   = 1'b0;
        lb1_rd   = 1'b0;
        if (in_range) begin
            lb0_rd = lb0[lb_addr];
            lb1_rd = lb1[lb_addr];
        end
        vs_rise  = vsync_in & ~vsync_s1_q;
        de_fall  = de_s1_q & ~de_in;
        valid_d  = (row_cnt_q >= TWO) && (col_cnt_q >= TWO) && in_range;
    end

    // Line buffers: read-before-write, contents need no reset since the
    // border masking never lets stale data reach the output.
    always_ff @(posedge clk) begin
        if (de_in && in_range) begin
            lb0[lb_addr] <= pix_in;
            lb1[lb_addr] <= lb0_rd;
        end
    end

    // Position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            if (!de_in) begin
                col_cnt_q <= '0;
            end else if (col_cnt_q != WIDTH_C) begin
                col_cnt_q <= col_cnt_q + ONE;
            end
            if (vs_rise) begin
                row_cnt_q <= '0;
            end else if (de_fall && (row_cnt_q != ROW_MAX)) begin
                row_cnt_q <= row_cnt_q + ONE;
            end
        end
    end

    // Stage 1: window shift and delayed controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_s1_q <= 1'b0;
            hsync_s1_q <= 1'b0;
            de_s1_q    <= 1'b0;
            pix_s1_q   <= 1'b0;
            valid_s1_q <= 1'b0;
            win_top_q  <= '0;
            win_mid_q  <= '0;
            win_bot_q  <= '0;
        end else begin
            vsync_s1_q <= vsync_in;
            hsync_s1_q <= hsync_in;
            de_s1_q    <= de_in;
            pix_s1_q   <= pix_in;
            valid_s1_q <= valid_d;
            if (de_in) begin
                win_top_q <= {win_top_q[1:0], lb1_rd};
                win_mid_q <= {win_mid_q[1:0], lb0_rd};
                win_bot_q <= {win_bot_q[1:0], pix_in};
            end
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_out <= 1'b0;
            hsync_out <= 1'b0;
            de_out    <= 1'b0;
            pix_out   <= 1'b0;
        end else begin
            vsync_out <= vsync_s1_q;
            hsync_out <= hsync_s1_q;
            de_out    <= de_s1_q;
            pix_out   <= de_s1_q & (erode_en ? (valid_s1_q & (&{win_top_q, win_mid_q, win_bot_q}))
                                             : pix_s1_q);
        end
    end

endmodule
